// File: rtl/aes_inv_key_schedule.sv
// Inverse AES-128 key schedule: emits round keys 10 down to 0 from the last round key.
// Latency: round-10 key valid 1 cycle after start; then one key per accepted beat.
// Backpressure: round_key/round_idx hold bit-stable while rk_valid && !rk_ready.
module aes_inv_key_schedule #(
  parameter int NR = 10,
  parameter int NK = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] last_key,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         busy,
  output logic         done
);

  // Only the AES-128 geometry is implemented; anything else must not elaborate.
  generate
    if (NR != 10 || NK != 4) begin : g_bad_cfg
      $error("aes_inv_key_schedule: only NR=10, NK=4 (AES-128) is supported");
    end
  endgenerate

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Rcon for the round whose key is being undone; round 0 has no predecessor.
  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  typedef enum logic {IDLE, EMIT} state_t;

  state_t       state, state_nxt;
  logic         rk_valid_nxt, busy_nxt, done_nxt;
  logic [127:0] round_key_nxt;
  logic [3:0]   round_idx_nxt;

  // Previous-round key: undo the word chain first, then the SubWord/RotWord mix on w0.
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  p0, p1, p2, p3;
  logic [31:0]  rot, sub;
  logic [127:0] prev_key;

  assign {w0, w1, w2, w3} = round_key;
  assign p3  = w3 ^ w2;
  assign p2  = w2 ^ w1;
  assign p1  = w1 ^ w0;
  assign rot = {p3[23:0], p3[31:24]};
  assign sub = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]};
  assign p0  = w0 ^ sub ^ {rcon(round_idx), 24'h0};
  assign prev_key = {p0, p1, p2, p3};

  // State and output registers; reset wins over everything and suppresses done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rk_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      round_key <= '0;
      round_idx <= '0;
    end else begin
      state     <= state_nxt;
      rk_valid  <= rk_valid_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      round_key <= round_key_nxt;
      round_idx <= round_idx_nxt;
    end
  end

  // Next-state logic: load on start in IDLE, step backwards one round per accepted beat.
  always_comb begin
    state_nxt     = state;
    rk_valid_nxt  = rk_valid;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    round_key_nxt = round_key;
    round_idx_nxt = round_idx;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt     = EMIT;
          rk_valid_nxt  = 1'b1;
          busy_nxt      = 1'b1;
          round_key_nxt = last_key;
          round_idx_nxt = 4'(NR);
        end
      end
      EMIT: begin
        if (rk_valid && rk_ready) begin
          if (round_idx != 4'd0) begin
            round_key_nxt = prev_key;
            round_idx_nxt = round_idx - 4'd1;
          end else begin
            state_nxt    = IDLE;
            rk_valid_nxt = 1'b0;
            busy_nxt     = 1'b0;
            done_nxt     = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Directed bench for the inverse AES-128 key schedule.
// Expected keys come from an independent forward key expansion plus FIPS-197 constants.
// Drives inputs and samples outputs on the falling clock edge.
module tb_aes_inv_key_schedule;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] last_key;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;
  logic [7:0]   lfsr = 8'ha5;
  logic [127:0] exp_rk [0:10];
  logic [127:0] got    [0:10];

  aes_inv_key_schedule dut (
    .clk(clk), .rst(rst), .start(start), .last_key(last_key),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .round_key(round_key),
    .round_idx(round_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] SB [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
  localparam logic [7:0] RC [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  localparam logic [127:0] KEY_A1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] LAST_A1 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] LAST_Z  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  // Forward AES-128 key expansion: fills exp_rk[0..10] from a cipher key.
  task automatic set_model(input logic [127:0] ck);
    logic [31:0] w [0:43];
    logic [31:0] t;
    {w[0], w[1], w[2], w[3]} = ck;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {SB[t[31:24]], SB[t[23:16]], SB[t[15:8]], SB[t[7:0]]} ^ {RC[i/4], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle at a falling edge; returns at the falling edge after acceptance.
  task automatic start_seq(input logic [127:0] k);
    chk("idle_valid", rk_valid, 0);
    start = 1'b1;
    last_key = k;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Consume one sequence against exp_rk. mode 0: ready=1; mode 1: stalls + pseudo-random ready.
  task automatic run_seq(input int mode, input int poke_idx, input int abort_idx,
                         input bit b2b, input logic [127:0] b2b_key);
    int exp_idx = 10;
    int stall = 0;
    int budget = 0;
    bit fin = 1'b0;
    while (!fin && budget < 400) begin
      chk("valid", rk_valid, 1);
      chk("busy", busy, 1);
      chk("done_low", done, 0);
      chk("idx", round_idx, exp_idx);
      chk("key", round_key, exp_rk[exp_idx]);
      if (exp_idx == abort_idx) begin
        rst = 1'b1;
        rk_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_valid", rk_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_key", round_key, 0);
        chk("abort_idx", round_idx, 0);
        repeat (3) begin
          @(negedge clk);
          chk("abort_no_done", done, 0);
        end
        fin = 1'b1;
      end else begin
        start = (exp_idx == poke_idx);
        if (exp_idx == poke_idx) last_key = 128'h0f0e0d0c0b0a09080706050403020100;
        if (mode == 0) rk_ready = 1'b1;
        else if ((exp_idx == 10 || exp_idx == 0) && stall < 5) rk_ready = 1'b0;
        else begin
          lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
          rk_ready = lfsr[0];
        end
        got[exp_idx] = round_key;
        @(negedge clk);
        budget++;
        start = 1'b0;
        if (rk_ready) begin
          if (exp_idx == 0) begin
            chk("done_pulse", done, 1);
            chk("done_busy", busy, 0);
            chk("done_valid", rk_valid, 0);
            if (b2b) begin
              start = 1'b1;
              last_key = b2b_key;
              @(negedge clk);
              start = 1'b0;
            end else begin
              @(negedge clk);
              chk("done_single", done, 0);
              chk("idle_valid_after", rk_valid, 0);
            end
            fin = 1'b1;
          end else begin
            exp_idx--;
            stall = 0;
          end
        end else begin
          stall++;
        end
      end
    end
    if (!fin) begin
      checks++;
      errors++;
      $error("FAIL timeout observed_idx=%0d expected=sequence_end", exp_idx);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    rk_ready = 1'b0;
    last_key = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", rk_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_key", round_key, 0);
    chk("rst_idx", round_idx, 0);
    rst = 1'b0;
    @(negedge clk);

    // FIPS-197 A.1 with ready held high
    set_model(KEY_A1);
    start_seq(LAST_A1);
    run_seq(0, -1, -1, 1'b0, '0);
    chk("a1_idx10", got[10], LAST_A1);
    chk("a1_idx9", got[9], 128'hac7766f319fadc2128d12941575c006e);
    chk("a1_idx1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("a1_idx0", got[0], KEY_A1);

    // Backpressure with stalls at idx10 and idx0
    start_seq(LAST_A1);
    run_seq(1, -1, -1, 1'b0, '0);
    chk("bp_idx0", got[0], KEY_A1);

    // All-zero cipher key
    set_model('0);
    start_seq(LAST_Z);
    run_seq(0, -1, -1, 1'b0, '0);
    chk("zero_idx0", got[0], 0);

    // start while busy is ignored
    set_model(KEY_A1);
    start_seq(LAST_A1);
    run_seq(0, 6, -1, 1'b0, '0);
    chk("poke_idx0", got[0], KEY_A1);

    // Reset mid-run, then a clean full sequence
    start_seq(LAST_A1);
    run_seq(0, -1, 4, 1'b0, '0);
    start_seq(LAST_A1);
    run_seq(0, -1, -1, 1'b0, '0);
    chk("post_rst_idx0", got[0], KEY_A1);

    // Back-to-back: second start in the done cycle
    start_seq(LAST_A1);
    run_seq(0, -1, -1, 1'b1, LAST_Z);
    set_model('0);
    run_seq(0, -1, -1, 1'b0, '0);
    chk("b2b_idx0", got[0], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_inv_key_schedule.md
Name: aes_inv_key_schedule

Overview:
- Iterative inverse AES-128 key schedule for the decryption datapath.
- Takes the final round key (round 10) and regenerates round keys 10, 9, …, 0 in order, one per accepted beat, over a valid/ready stream.
- Saves storing all 11 round keys: the decrypt round engine loads the round-10 key once and pulls the earlier keys on demand.
- Round 0 output equals the original cipher key, so the same block also recovers the cipher key from a last-round key.

Parameters:
- NR, 10, number of rounds; only 10 is legal (AES-128). Any other value is a configuration error flagged by an elaboration-time check.
- NK, 4, key length in 32-bit words; only 4 is legal.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request to load last_key; sampled only in IDLE
- last_key  input  128  round-10 key; byte 0 is in the most-significant byte, word w0 = bits 127:96
- rk_valid  output  1  round_key/round_idx are valid
- rk_ready  input  1  consumer accepts the current key when rk_valid && rk_ready
- round_key  output  128  current round key, same byte order as last_key
- round_idx  output  4  round number of round_key, 10 down to 0
- busy  output  1  high from the cycle after start acceptance until the round-0 key is accepted
- done  output  1  single-cycle pulse after the round-0 key is accepted

Behaviour:
- Reset values: rk_valid=0, busy=0, done=0, round_key=0, round_idx=0, state=IDLE. Reset has priority over every other input.
- FSM states:
  - IDLE: start=1 → load round_key=last_key, round_idx=10, rk_valid=1, busy=1, go to EMIT. Latency is 1 cycle from the start sample to rk_valid.
  - EMIT, accept with round_idx>0: next cycle round_key=prev(round_key, round_idx), round_idx decrements by 1, rk_valid stays 1.
  - EMIT, accept with round_idx=0: next cycle rk_valid=0, busy=0, done=1 for one cycle, return to IDLE.
  - EMIT, no accept (rk_valid && !rk_ready): round_key and round_idx held bit-stable.
- prev(k, i), with k = w0..w3:
  - w3' = w3^w2
  - w2' = w2^w1
  - w1' = w1^w0
  - w0' = w0 ^ SubWord(RotWord(w3')) ^ {Rcon(i), 24'h0}
  - RotWord rotates bytes left by one: [a,b,c,d] → [b,c,d,a].
  - SubWord applies the forward AES S-box to each byte; four S-box instances.
- Rcon(i) table for i=1..10: 01,02,04,08,10,20,40,80,1b,36. i=0 never applies.
- Throughput: with rk_ready held at 1, 11 keys on 11 consecutive cycles; done appears in the 12th cycle after rk_valid first rises.
- start while busy=1 is ignored; last_key is sampled only on acceptance in IDLE.
- start in the same cycle as done (already in IDLE) is accepted; the new sequence starts on the next cycle.
- rk_ready while rk_valid=0 has no effect.
- Reset mid-sequence aborts immediately: no done pulse, outputs take reset values on the next cycle.
- Datapath is purely combinational between the key register and the next-key register; no multicycle paths.

Test Plan:
- FIPS-197 A.1, ready=1:
  - last_key=d014f9a8c9ee2589e13f0cc8b6630ca6, start pulse.
  - Required: idx10=d014f9a8…0ca6, idx9=ac7766f319fadc2128d12941575c006e, idx1=a0fafe1788542cb123a339392a6c7605, idx0=2b7e151628aed2a6abf7158809cf4f3c.
  - Required: done 1 cycle after the idx0 accept, busy low with it.
- Backpressure:
  - Same key; rk_ready toggled in a pseudo-random pattern, including 5-cycle stalls at idx10 and idx0.
  - Required: key and idx stable during stalls; same 11-key sequence in order; no skipped or duplicated idx.
- All-zero key:
  - last_key = forward round-10 key of cipher key 0 (b4ef5bcb3e92e21123e951cf6f8f188e).
  - Required: idx0 = 0.
- start during busy:
  - Pulse start with a different last_key at idx 6.
  - Required: sequence unaffected, idx0 still equals the original cipher key.
- Reset mid-run:
  - rst=1 at idx 4.
  - Required: next cycle rk_valid=0, busy=0, done never pulses.
  - A new start then produces a correct full sequence.
- Back-to-back:
  - start asserted in the done cycle with a second key.
  - Required: second sequence's idx10 valid the following cycle; both sequences bit-exact against the software model.
